// File: rtl/button_cmd_if.sv
// ---------------------------------------------------------------------------
// button_cmd_if
// Command handshake between the button front-end and the time/alarm control
// FSM. A command is transferred on a clock where cmd_valid and cmd_ready are
// both high; cmd_id holds steady for as long as cmd_valid is high.
//
// Signals
//   cmd_valid  master -> slave   command offered
//   cmd_id     master -> slave   index of the pressed button
//   cmd_ready  slave  -> master  consumer accepts the offered command
// ---------------------------------------------------------------------------
interface button_cmd_if #(
    parameter int N_BTN = 5
);
    localparam int ID_W = $clog2(N_BTN);

    logic            cmd_valid;
    logic [ID_W-1:0] cmd_id;
    logic            cmd_ready;

    modport master (
        output cmd_valid,
        output cmd_id,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_id,
        output cmd_ready
    );
endinterface

// File: rtl/button_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// button_cmd_arbiter
// Front-end for the alarm-clock push buttons. Each button goes through a
// 2-flop synchronizer, a tick-sampled debouncer and a rising-edge detector.
// Presses are latched as pending bits, and a round-robin arbiter hands them
// one at a time to the control FSM over a valid/ready handshake.
//
// Optional feature: define BUTTON_CMD_AUTO_REPEAT_EN to enable auto-repeat.
// A held button then re-raises its pending bit after RPT_DELAY ticks, and
// every RPT_PERIOD ticks after that. Without the macro, each debounced press
// produces exactly one command.
//
// Ports
//   i_clk        in   1                system clock
//   i_rst_n      in   1                asynchronous reset, active-low
//   i_tick       in   1                1-clk sample strobe for debouncing
//   i_btn_raw    in   N_BTN            asynchronous raw button levels, 1 = pressed
//   o_btn_level  out  N_BTN            debounced button levels
//   cmd_bus      master modport        cmd_valid / cmd_id / cmd_ready
//
// Arbiter states
//   state     | meaning
//   ST_IDLE   | no command offered; grant the next pending button if any
//   ST_OFFER  | cmd_valid high, cmd_id held until cmd_ready
// ---------------------------------------------------------------------------
module button_cmd_arbiter #(
    parameter int N_BTN      = 5,
    parameter int DB_TICKS   = 4,
    parameter int RPT_DELAY  = 50,
    parameter int RPT_PERIOD = 10
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_tick,
    input  logic [N_BTN-1:0] i_btn_raw,
    output logic [N_BTN-1:0] o_btn_level,
    button_cmd_if.master     cmd_bus
);
    localparam int         ID_W    = $clog2(N_BTN);
    localparam logic [3:0] DB_LAST = 4'(DB_TICKS - 1);

    // Elaboration-time parameter range guards.
    if (N_BTN < 2 || N_BTN > 8) begin : g_bad_n_btn
        $error("button_cmd_arbiter: N_BTN must be 2..8");
    end
    if (DB_TICKS < 1 || DB_TICKS > 15) begin : g_bad_db_ticks
        $error("button_cmd_arbiter: DB_TICKS must be 1..15");
    end
    if (RPT_DELAY < 1 || RPT_DELAY > 255 || RPT_PERIOD < 1 || RPT_PERIOD > 255) begin : g_bad_rpt
        $error("button_cmd_arbiter: RPT_DELAY and RPT_PERIOD must be 1..255");
    end

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;
    logic [N_BTN-1:0] r_level;
    logic [N_BTN-1:0] r_level_d;
    logic [3:0]       r_db_cnt [N_BTN];
    logic [N_BTN-1:0] r_pending;

    state_t           r_state;
    logic             r_cmd_valid;
    logic [ID_W-1:0]  r_cmd_id;
    logic [ID_W-1:0]  r_rr_ptr;

    logic [N_BTN-1:0] w_rise;
    logic [N_BTN-1:0] w_set;
    logic [N_BTN-1:0] w_clr;
    logic             w_grant_vld;
    logic [ID_W-1:0]  w_grant;

    // Synchronizer runs every clock; only the debouncer is tick-gated.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: count consecutive ticks on which the synced level disagrees
    // with the debounced level; toggle after DB_TICKS of them in a row.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_level   <= '0;
            r_level_d <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_level_d <= r_level;
            if (i_tick) begin
                for (int i = 0; i < N_BTN; i++) begin
                    if (r_sync2[i] == r_level[i]) begin
                        r_db_cnt[i] <= '0;
                    end else if (r_db_cnt[i] == DB_LAST) begin
                        r_level[i]  <= ~r_level[i];
                        r_db_cnt[i] <= '0;
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + 4'd1;
                    end
                end
            end
        end
    end

    assign w_rise      = r_level & ~r_level_d;
    assign o_btn_level = r_level;

`ifdef BUTTON_CMD_AUTO_REPEAT_EN
    localparam logic [7:0] RPT_DELAY_M1  = 8'(RPT_DELAY - 1);
    localparam logic [7:0] RPT_PERIOD_M1 = 8'(RPT_PERIOD - 1);

    logic [7:0]       r_hold_cnt [N_BTN];
    logic [N_BTN-1:0] r_rpt_armed;     // first repeat already issued for this hold
    logic [N_BTN-1:0] w_rpt;

    // The hold counter restarts after each repeat, so one 8-bit counter
    // covers both the initial delay and the repeat period.
    always_comb begin
        w_rpt = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (i_tick && r_level[i] && !w_rise[i]) begin
                w_rpt[i] = r_rpt_armed[i] ? (r_hold_cnt[i] == RPT_PERIOD_M1)
                                          : (r_hold_cnt[i] == RPT_DELAY_M1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rpt_armed <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                r_hold_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (w_rise[i] || !r_level[i]) begin
                    r_hold_cnt[i]  <= '0;
                    r_rpt_armed[i] <= 1'b0;
                end else if (i_tick) begin
                    if (w_rpt[i]) begin
                        r_hold_cnt[i]  <= '0;
                        r_rpt_armed[i] <= 1'b1;
                    end else begin
                        r_hold_cnt[i] <= r_hold_cnt[i] + 8'd1;
                    end
                end
            end
        end
    end

    assign w_set = w_rise | w_rpt;
`else
    assign w_set = w_rise;
`endif

    // Clear only the bit whose command is accepted this clock.
    always_comb begin
        w_clr = '0;
        if (r_state == ST_OFFER && cmd_bus.cmd_ready) begin
            w_clr[r_cmd_id] = 1'b1;
        end
    end

    // Set is applied after clear so a press landing on the accept clock wins.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_set;
        end
    end

    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int k);
        int sum;
        sum = int'(base) + k;
        if (sum >= N_BTN) begin
            sum = sum - N_BTN;
        end
        return ID_W'(sum);
    endfunction

    // Scan downwards so the lowest offset from rr_ptr wins.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant     = '0;
        for (int k = N_BTN - 1; k >= 0; k--) begin
            if (r_pending[wrap_add(r_rr_ptr, k)]) begin
                w_grant_vld = 1'b1;
                w_grant     = wrap_add(r_rr_ptr, k);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_cmd_valid <= 1'b0;
            r_cmd_id    <= '0;
            r_rr_ptr    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_vld) begin
                        r_cmd_id    <= w_grant;
                        r_cmd_valid <= 1'b1;
                        r_state     <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (cmd_bus.cmd_ready) begin
                        r_cmd_valid <= 1'b0;
                        r_rr_ptr    <= (r_cmd_id == ID_W'(N_BTN - 1)) ? '0 : r_cmd_id + ID_W'(1);
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_cmd_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_bus.cmd_valid = r_cmd_valid;
    assign cmd_bus.cmd_id    = r_cmd_id;
endmodule
